// File: rtl/perceptron_trainer.sv
// Trainer front-end for a 2-input perceptron: streams labelled samples in, waits for
// the perceptron to settle, applies the saturating learning rule and tracks epoch errors.
module perceptron_trainer #(
  parameter int W_WIDTH       = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int LR            = 1,
  parameter int W1_INIT       = 0,
  parameter int W2_INIT       = 0,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        train_en,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_x1,
  input  logic                        s_x2,
  input  logic                        s_target,
  input  logic                        s_last,
  output logic                        v_in1,
  output logic                        v_in2,
  output logic signed [W_WIDTH-1:0]   w1_out,
  output logic signed [W_WIDTH-1:0]   w2_out,
  input  logic                        p_v_out,
  output logic                        r_valid,
  output logic                        r_pred,
  output logic                        r_error,
  output logic                        epoch_done,
  output logic [ERR_CNT_W-1:0]        epoch_errors,
  output logic                        converged
);

  localparam int SW = W_WIDTH + 3;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic signed [SW-1:0] W_MAX    = SW'((1 << (W_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] W_MIN    = SW'(-(1 << (W_WIDTH - 1)));
  localparam logic signed [SW-1:0] LR_S     = SW'(LR);
  localparam logic [CW-1:0]        CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, EVAL = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       v1_q, v1_d, v2_q, v2_d;
  logic                       tgt_q, tgt_d, last_q, last_d;
  logic signed [W_WIDTH-1:0]  w1_q, w1_d, w2_q, w2_d;
  logic                       r_valid_q, r_valid_d, r_pred_q, r_pred_d;
  logic                       r_error_q, r_error_d, epoch_done_q, epoch_done_d;
  logic [ERR_CNT_W-1:0]       epoch_errors_q, epoch_errors_d;
  logic                       converged_q, converged_d;
  logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_d, err_cnt_inc;
  logic                       eval_err;

  // err is +1 when the target is 1 (weights step up), -1 when it is 0.
  function automatic logic signed [W_WIDTH-1:0] sat_step(
    input logic signed [W_WIDTH-1:0] w,
    input logic                      x,
    input logic                      up
  );
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    step = x ? (up ? LR_S : -LR_S) : '0;
    sum  = {{3{w[W_WIDTH-1]}}, w} + step;
    if (sum > W_MAX)      sat_step = W_MAX[W_WIDTH-1:0];
    else if (sum < W_MIN) sat_step = W_MIN[W_WIDTH-1:0];
    else                  sat_step = sum[W_WIDTH-1:0];
  endfunction

  assign eval_err    = p_v_out ^ tgt_q;
  assign err_cnt_inc = (eval_err && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      tgt_q          <= 1'b0;
      last_q         <= 1'b0;
      w1_q           <= W_WIDTH'(W1_INIT);
      w2_q           <= W_WIDTH'(W2_INIT);
      r_valid_q      <= 1'b0;
      r_pred_q       <= 1'b0;
      r_error_q      <= 1'b0;
      epoch_done_q   <= 1'b0;
      epoch_errors_q <= '0;
      converged_q    <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      tgt_q          <= tgt_d;
      last_q         <= last_d;
      w1_q           <= w1_d;
      w2_q           <= w2_d;
      r_valid_q      <= r_valid_d;
      r_pred_q       <= r_pred_d;
      r_error_q      <= r_error_d;
      epoch_done_q   <= epoch_done_d;
      epoch_errors_q <= epoch_errors_d;
      converged_q    <= converged_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    v1_d           = v1_q;
    v2_d           = v2_q;
    tgt_d          = tgt_q;
    last_d         = last_q;
    w1_d           = w1_q;
    w2_d           = w2_q;
    r_valid_d      = 1'b0;
    r_pred_d       = r_pred_q;
    r_error_d      = r_error_q;
    epoch_done_d   = 1'b0;
    epoch_errors_d = epoch_errors_q;
    converged_d    = converged_q;
    err_cnt_d      = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          v1_d    = s_x1;
          v2_d    = s_x2;
          tgt_d   = s_target;
          last_d  = s_last;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = EVAL;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      EVAL: begin
        if (train_en && eval_err) begin
          w1_d = sat_step(w1_q, v1_q, tgt_q);
          w2_d = sat_step(w2_q, v2_q, tgt_q);
        end
        r_valid_d = 1'b1;
        r_pred_d  = p_v_out;
        r_error_d = eval_err;
        // Closing an epoch folds this sample's error into the reported count.
        if (last_q) begin
          epoch_errors_d = err_cnt_inc;
          converged_d    = (err_cnt_inc == '0);
          err_cnt_d      = '0;
          epoch_done_d   = 1'b1;
        end else begin
          err_cnt_d      = err_cnt_inc;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready      = (state_q == IDLE);
  assign v_in1        = v1_q;
  assign v_in2        = v2_q;
  assign w1_out       = w1_q;
  assign w2_out       = w2_q;
  assign r_valid      = r_valid_q;
  assign r_pred       = r_pred_q;
  assign r_error      = r_error_q;
  assign epoch_done   = epoch_done_q;
  assign epoch_errors = epoch_errors_q;
  assign converged    = converged_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: drives samples, plays the perceptron (forced or closed-loop)
// and checks results against an arithmetic model of the learning rule and epoch counting.
module tb_perceptron_trainer;
  localparam int W  = 3;
  localparam int S  = 2;
  localparam int LR = 1;
  localparam int EW = 4;

  logic clk = 1'b0, reset_n = 1'b0, train_en = 1'b0, s_valid = 1'b0;
  logic s_x1 = 1'b0, s_x2 = 1'b0, s_target = 1'b0, s_last = 1'b0, p_v_out = 1'b0;
  logic s_ready, v_in1, v_in2, r_valid, r_pred, r_error, epoch_done, converged;
  logic signed [W-1:0] w1_out, w2_out;
  logic [EW-1:0] epoch_errors;

  int nvec = 0, nerr = 0, cyc = 0;
  logic closed = 1'b0, p_forced = 1'b0;
  int mw1, mw2, mcnt, mepoch;
  bit mconv;
  int ob_cyc, ob_w1, ob_w2, ob_eerr;
  logic ob_pred, ob_err, ob_edone, ob_conv;

  perceptron_trainer #(.W_WIDTH(W), .SETTLE_CYCLES(S), .LR(LR), .W1_INIT(0), .W2_INIT(0),
                       .ERR_CNT_W(EW)) dut (
    .clk(clk), .reset_n(reset_n), .train_en(train_en), .s_valid(s_valid), .s_ready(s_ready),
    .s_x1(s_x1), .s_x2(s_x2), .s_target(s_target), .s_last(s_last),
    .v_in1(v_in1), .v_in2(v_in2), .w1_out(w1_out), .w2_out(w2_out), .p_v_out(p_v_out),
    .r_valid(r_valid), .r_pred(r_pred), .r_error(r_error), .epoch_done(epoch_done),
    .epoch_errors(epoch_errors), .converged(converged));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench perceptron: fires when the weighted sum reaches 2.
  function automatic logic perc(input int w1, input int w2, input logic a, input logic b);
    return (w1 * int'(a) + w2 * int'(b)) >= 2;
  endfunction

  always @(posedge clk) p_v_out <= closed ? perc(int'(w1_out), int'(w2_out), v_in1, v_in2) : p_forced;

  function automatic int clamp(input int v);
    int lo, hi;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic model_reset();
    mw1 = 0; mw2 = 0; mcnt = 0; mepoch = 0; mconv = 0;
  endtask

  task automatic model_step(input logic x1, x2, tgt, last, p, ten);
    int e;
    e = int'(tgt) - int'(p);
    if (ten && e != 0) begin
      mw1 = clamp(mw1 + e * LR * int'(x1));
      mw2 = clamp(mw2 + e * LR * int'(x2));
    end
    if (e != 0 && mcnt < (1 << EW) - 1) mcnt = mcnt + 1;
    if (last) begin
      mepoch = mcnt;
      mconv  = (mcnt == 0);
      mcnt   = 0;
    end
  endtask

  task automatic run_sample(input logic x1, x2, tgt, last, pf, ten);
    int n;
    @(negedge clk);
    s_x1 = x1; s_x2 = x2; s_target = tgt; s_last = last;
    p_forced = pf; train_en = ten; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 s_valid = 1'b0;
    ob_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (r_valid) begin ob_cyc = i; break; end
    end
    ob_pred = r_pred; ob_err = r_error; ob_w1 = int'(w1_out); ob_w2 = int'(w2_out);
    ob_edone = epoch_done; ob_eerr = int'(epoch_errors); ob_conv = converged;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL rst_s_ready got %b want 1", s_ready); end
    nvec++; if (r_valid !== 1'b0) begin nerr++; $display("FAIL rst_r_valid got %b want 0", r_valid); end
    nvec++; if (w1_out !== 3'sd0) begin nerr++; $display("FAIL rst_w1 got %0d want 0", w1_out); end
    nvec++; if (w2_out !== 3'sd0) begin nerr++; $display("FAIL rst_w2 got %0d want 0", w2_out); end
    nvec++; if (epoch_errors !== 4'd0) begin nerr++; $display("FAIL rst_epoch_errors got %0d want 0", epoch_errors); end
    nvec++; if ({converged, epoch_done, v_in1, v_in2} !== 4'b0) begin nerr++; $display("FAIL rst_misc got %b want 0000", {converged, epoch_done, v_in1, v_in2}); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_update();
    run_sample(1, 1, 0, 0, 1, 1);
    model_step(1, 1, 0, 0, 1, 1);
    nvec++; if (ob_cyc !== S + 1) begin nerr++; $display("FAIL single_latency got %0d want %0d", ob_cyc, S + 1); end
    nvec++; if (ob_err !== 1'b1) begin nerr++; $display("FAIL single_r_error got %b want 1", ob_err); end
    nvec++; if (ob_pred !== 1'b1) begin nerr++; $display("FAIL single_r_pred got %b want 1", ob_pred); end
    nvec++; if (ob_w1 !== -1) begin nerr++; $display("FAIL single_w1 got %0d want -1", ob_w1); end
    nvec++; if (ob_w2 !== -1) begin nerr++; $display("FAIL single_w2 got %0d want -1", ob_w2); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8 && mw1 < 3; i++) begin run_sample(1, 0, 1, 0, 0, 1); model_step(1, 0, 1, 0, 0, 1); end
    for (int i = 0; i < 8 && mw2 > -4; i++) begin run_sample(0, 1, 0, 0, 1, 1); model_step(0, 1, 0, 0, 1, 1); end
    nvec++; if (ob_w1 !== 3 || ob_w2 !== -4) begin nerr++; $display("FAIL sat_reach got (%0d,%0d) want (3,-4)", ob_w1, ob_w2); end
    run_sample(1, 0, 1, 0, 0, 1);
    model_step(1, 0, 1, 0, 0, 1);
    nvec++; if (ob_w1 !== 3) begin nerr++; $display("FAIL sat_w1_hi got %0d want 3", ob_w1); end
    nvec++; if (ob_w2 !== -4) begin nerr++; $display("FAIL sat_w2_x0 got %0d want -4", ob_w2); end
    nvec++; if (ob_err !== 1'b1) begin nerr++; $display("FAIL sat_err got %b want 1", ob_err); end
    run_sample(0, 1, 0, 0, 1, 1);
    model_step(0, 1, 0, 0, 1, 1);
    nvec++; if (ob_w2 !== -4) begin nerr++; $display("FAIL sat_w2_lo got %0d want -4", ob_w2); end
    nvec++; if (ob_w1 !== 3) begin nerr++; $display("FAIL sat_w1_x0 got %0d want 3", ob_w1); end
  endtask

  task automatic test_train_off();
    int pw1, pw2;
    pw1 = mw1; pw2 = mw2;
    run_sample(1, 1, 1, 0, 0, 0);
    model_step(1, 1, 1, 0, 0, 0);
    nvec++; if (ob_err !== 1'b1) begin nerr++; $display("FAIL off_err got %b want 1", ob_err); end
    nvec++; if (ob_w1 !== pw1 || ob_w2 !== pw2) begin nerr++; $display("FAIL off_weights got (%0d,%0d) want (%0d,%0d)", ob_w1, ob_w2, pw1, pw2); end
    run_sample(0, 0, 0, 1, 0, 1);
    model_step(0, 0, 0, 1, 0, 1);
    nvec++; if (ob_edone !== 1'b1) begin nerr++; $display("FAIL off_epoch_done got %b want 1", ob_edone); end
    nvec++; if (ob_eerr !== mepoch) begin nerr++; $display("FAIL off_epoch_errors got %0d want %0d", ob_eerr, mepoch); end
    nvec++; if (ob_conv !== 1'b0) begin nerr++; $display("FAIL off_converged got %b want 0", ob_conv); end
  endtask

  task automatic test_random();
    logic x1, x2, tgt, last, pf, ten;
    for (int i = 0; i < 40; i++) begin
      x1 = 1'($urandom); x2 = 1'($urandom); tgt = 1'($urandom);
      pf = 1'($urandom); ten = 1'($urandom); last = ($urandom_range(0, 3) == 0);
      run_sample(x1, x2, tgt, last, pf, ten);
      model_step(x1, x2, tgt, last, pf, ten);
      nvec++; if (ob_cyc !== S + 1) begin nerr++; $display("FAIL rnd%0d_latency got %0d want %0d", i, ob_cyc, S + 1); end
      nvec++; if (ob_pred !== pf) begin nerr++; $display("FAIL rnd%0d_pred got %b want %b", i, ob_pred, pf); end
      nvec++; if (ob_err !== (pf ^ tgt)) begin nerr++; $display("FAIL rnd%0d_err got %b want %b", i, ob_err, pf ^ tgt); end
      nvec++; if (ob_w1 !== mw1 || ob_w2 !== mw2) begin nerr++; $display("FAIL rnd%0d_weights got (%0d,%0d) want (%0d,%0d)", i, ob_w1, ob_w2, mw1, mw2); end
      nvec++; if (ob_edone !== last) begin nerr++; $display("FAIL rnd%0d_epoch_done got %b want %b", i, ob_edone, last); end
      nvec++; if (ob_eerr !== mepoch || ob_conv !== mconv) begin nerr++; $display("FAIL rnd%0d_epoch got (%0d,%b) want (%0d,%b)", i, ob_eerr, ob_conv, mepoch, mconv); end
    end
  endtask

  task automatic test_reset_mid();
    int rv;
    @(negedge clk);
    s_x1 = 1'b1; s_x2 = 1'b1; s_target = 1'b0; s_last = 1'b1; p_forced = 1'b1; train_en = 1'b1;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    nvec++; if (w1_out !== 3'sd0 || w2_out !== 3'sd0) begin nerr++; $display("FAIL midrst_weights got (%0d,%0d) want (0,0)", w1_out, w2_out); end
    nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL midrst_s_ready got %b want 1", s_ready); end
    nvec++; if (r_valid !== 1'b0) begin nerr++; $display("FAIL midrst_r_valid got %b want 0", r_valid); end
    nvec++; if (epoch_errors !== 4'd0) begin nerr++; $display("FAIL midrst_epoch_errors got %0d want 0", epoch_errors); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    rv = 0;
    repeat (8) begin @(negedge clk); if (r_valid) rv++; end
    nvec++; if (rv !== 0) begin nerr++; $display("FAIL midrst_discard got %0d results want 0", rv); end
  endtask

  task automatic test_epochs();
    logic x1, x2, p;
    int fw1, fw2;
    closed = 1'b1;
    for (int ep = 0; ep < 10; ep++) begin
      for (int k = 0; k < 4; k++) begin
        x1 = k[1]; x2 = k[0];
        p = perc(mw1, mw2, x1, x2);
        run_sample(x1, x2, x1 & x2, k == 3, 0, 1);
        model_step(x1, x2, x1 & x2, k == 3, p, 1);
        nvec++; if (ob_pred !== p) begin nerr++; $display("FAIL ep%0d_s%0d_pred got %b want %b", ep, k, ob_pred, p); end
        nvec++; if (ob_w1 !== mw1 || ob_w2 !== mw2) begin nerr++; $display("FAIL ep%0d_s%0d_weights got (%0d,%0d) want (%0d,%0d)", ep, k, ob_w1, ob_w2, mw1, mw2); end
        nvec++; if (ob_edone !== (k == 3)) begin nerr++; $display("FAIL ep%0d_s%0d_epoch_done got %b want %b", ep, k, ob_edone, k == 3); end
      end
      nvec++; if (ob_eerr !== mepoch || ob_conv !== mconv) begin nerr++; $display("FAIL ep%0d_summary got (%0d,%b) want (%0d,%b)", ep, ob_eerr, ob_conv, mepoch, mconv); end
      if (mconv) break;
    end
    nvec++; if (ob_conv !== 1'b1 || ob_eerr !== 0) begin nerr++; $display("FAIL ep_converged got (%0d,%b) want (0,1)", ob_eerr, ob_conv); end
    fw1 = ob_w1; fw2 = ob_w2;
    for (int k = 0; k < 4; k++) begin
      x1 = k[1]; x2 = k[0];
      run_sample(x1, x2, x1 & x2, k == 3, 0, 1);
    end
    nvec++; if (ob_w1 !== fw1 || ob_w2 !== fw2) begin nerr++; $display("FAIL ep_stable got (%0d,%0d) want (%0d,%0d)", ob_w1, ob_w2, fw1, fw2); end
    nvec++; if (ob_conv !== 1'b1 || ob_eerr !== 0 || ob_edone !== 1'b1) begin nerr++; $display("FAIL ep_stable_epoch got (%0d,%b,%b) want (0,1,1)", ob_eerr, ob_conv, ob_edone); end
    closed = 1'b0;
  endtask

  task automatic test_flow();
    int acc[$];
    int rv, nr;
    @(negedge clk);
    train_en = 1'b0; p_forced = 1'b0; s_target = 1'b0; s_last = 1'b0;
    s_x1 = 1'($urandom); s_x2 = 1'($urandom); s_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (s_ready) acc.push_back(cyc);
      @(negedge clk);
    end
    s_valid = 1'b0;
    nvec++; if (acc.size() < 3) begin nerr++; $display("FAIL flow_accepts got %0d want >=3", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      nvec++; if (acc[i] - acc[i-1] !== S + 2) begin nerr++; $display("FAIL flow_spacing%0d got %0d want %0d", i, acc[i] - acc[i-1], S + 2); end
    end
    repeat (6) @(negedge clk);
    rv = 0; nr = 0;
    repeat (10) begin @(negedge clk); if (r_valid) rv++; if (!s_ready) nr++; end
    nvec++; if (rv !== 0) begin nerr++; $display("FAIL flow_idle_r_valid got %0d want 0", rv); end
    nvec++; if (nr !== 0) begin nerr++; $display("FAIL flow_idle_s_ready got %0d low cycles want 0", nr); end
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_saturation();
    test_train_off();
    test_random();
    test_reset_mid();
    test_epochs();
    test_flow();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timeout");
  end
endmodule
